// File: rtl/agp_acc_engine.sv
// Queued reduction accelerator: operands enter a DEPTH-entry FIFO, a fixed-latency engine
// reduces each one, and results leave on a valid/ready channel.
//   state   | meaning
//   IDLE    | engine empty, pops the queue head when one is present
//   COMPUTE | latched operand counting down its latency
//   HOLD    | result presented, waiting for res_ready
module agp_acc_engine #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arg_valid,
  output logic                       arg_ready,
  input  logic [DATA_W-1:0]          arg_data,
  input  logic [1:0]                 arg_mode,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       busy
);
  localparam int H  = DATA_W / 2;
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

  state_t            state;
  logic [DATA_W+1:0] mem [2**PW];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] op_data;
  logic [1:0]        op_mode;
  logic [DATA_W-1:0] op_result;
  logic              push, pop, full;

  function automatic logic [DATA_W-1:0] reduce(input logic [1:0] m, input logic [DATA_W-1:0] a);
    logic [H:0]        hsum;
    logic [DATA_W-1:0] acc;
    hsum = {1'b0, a[DATA_W-1:H]} + {1'b0, a[H-1:0]};
    acc  = '0;
    case (m)
      2'd0: acc = DATA_W'(hsum);
      2'd1: for (int i = 0; i < NB; i++) acc = acc + DATA_W'(a[8*i +: 8]);
      2'd2: for (int i = 0; i < DATA_W; i++) acc = acc + DATA_W'(a[i]);
      default: acc = hsum[H] ? DATA_W'({H{1'b1}}) : DATA_W'(hsum);
    endcase
    return acc;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready and pop both look only at registered occupancy, so a same-edge pop
  // never frees a slot for a push, and a fresh entry waits one edge before popping.
  assign full      = (occupancy == OW'(DEPTH));
  assign arg_ready = !rst && !full;
  assign push      = arg_valid && arg_ready;
  assign pop       = (occupancy != '0) && ((state == IDLE) || (state == HOLD && res_ready));
  assign busy      = (state != IDLE) || (occupancy != '0);
  assign op_result = reduce(op_mode, op_data);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {arg_mode, arg_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      cnt       <= '0;
      op_data   <= '0;
      op_mode   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
      case (state)
        IDLE: if (pop) state <= COMPUTE;
        COMPUTE: begin
          if (cnt == '0) begin
            res_data  <= op_result;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= pop ? COMPUTE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        {op_mode, op_data} <= mem[rd_ptr];
        rd_ptr             <= next_ptr(rd_ptr);
        cnt                <= CW'(LATENCY - 1);
      end
    end
  end
endmodule

// File: tb/tb_agp_acc_engine.sv
// Directed bench for agp_acc_engine: default instance for queue/FSM behaviour,
// plus a LATENCY=1/DEPTH=1 instance for the minimum-latency path.
module tb_agp_acc_engine;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arg_valid, arg_ready, res_valid, res_ready, busy;
  logic [31:0] arg_data, res_data;
  logic [1:0]  arg_mode;
  logic [2:0]  occupancy;

  logic        b_rst, b_arg_valid, b_arg_ready, b_res_valid, b_res_ready, b_busy;
  logic [31:0] b_arg_data, b_res_data;
  logic [1:0]  b_arg_mode;
  logic [0:0]  b_occupancy;

  agp_acc_engine #(.DATA_W(32), .DEPTH(4), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .arg_data(arg_data), .arg_mode(arg_mode), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .occupancy(occupancy), .busy(busy));

  agp_acc_engine #(.DATA_W(32), .DEPTH(1), .LATENCY(1)) u1 (
    .clk(clk), .rst(b_rst), .arg_valid(b_arg_valid), .arg_ready(b_arg_ready),
    .arg_data(b_arg_data), .arg_mode(b_arg_mode), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_data(b_res_data), .occupancy(b_occupancy), .busy(b_busy));

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_exp;
  logic        last_push;
  int          seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge on u0, tracking accepted pushes and result handshakes against exp_q.
  task automatic cyc();
    logic        hs, ps;
    logic [31:0] d;
    hs = res_valid && res_ready;
    ps = arg_valid && arg_ready;
    d  = res_data;
    tick();
    last_push = ps;
    if (hs) begin
      if (exp_q.size() == 0) chk("res_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("res_data_order", d, exp_q.pop_front());
    end
    if (ps) exp_q.push_back(pend_exp);
  endtask

  task automatic push_op(input logic [31:0] d, input logic [1:0] m, input logic [31:0] e);
    arg_valid = 1'b1; arg_data = d; arg_mode = m; pend_exp = e;
    last_push = 1'b0;
    for (int i = 0; i < 20 && !last_push; i++) cyc();
    arg_valid = 1'b0;
    chk("push_accepted", 32'(last_push), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_five();
    push_op(32'h0001_0001, 2'd0, 32'h2);
    push_op(32'h0002_0003, 2'd0, 32'h5);
    push_op(32'h0000_000F, 2'd2, 32'h4);
    push_op(32'h0102_0304, 2'd1, 32'hA);
    push_op(32'hFFFF_0001, 2'd3, 32'hFFFF);
  endtask

  initial begin
    rst = 1'b1; arg_valid = 1'b0; arg_data = '0; arg_mode = '0; res_ready = 1'b1;
    b_rst = 1'b1; b_arg_valid = 1'b0; b_arg_data = '0; b_arg_mode = '0; b_res_ready = 1'b1;
    pend_exp = '0; last_push = 1'b0; seen = 0;
    tick(); tick();
    chk("rst_arg_ready", 32'(arg_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("idle_arg_ready", 32'(arg_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1: latency of exactly two edges after the pop
    arg_valid = 1'b1; arg_data = 32'h0003_0005; arg_mode = 2'd0;
    tick();
    arg_valid = 1'b0;
    chk("t1_queued", 32'(occupancy), 32'd1);
    tick();
    chk("t1_popped", 32'(occupancy), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_pop+1", 32'(res_valid), 32'd0);
    tick();
    chk("t1_valid_pop+1b", 32'(res_valid), 32'd1 - 32'd1);
    tick();
    chk("t1_valid_pop+2", 32'(res_valid), 32'd1);
    chk("t1_data", res_data, 32'h8);
    tick();
    chk("t1_after_hs_valid", 32'(res_valid), 32'd0);
    chk("t1_after_hs_busy", 32'(busy), 32'd0);

    // 2: all four ops on all-ones, results in order
    push_op(32'hFFFF_FFFF, 2'd0, 32'h1_FFFE);
    push_op(32'hFFFF_FFFF, 2'd1, 32'h3FC);
    push_op(32'hFFFF_FFFF, 2'd3, 32'hFFFF);
    push_op(32'hFFFF_FFFF, 2'd2, 32'h20);
    drain("t2_drained");

    // 3: stalled consumer fills the queue, nothing lost
    res_ready = 1'b0;
    push_five();
    chk("t3_occupancy", 32'(occupancy), 32'd4);
    chk("t3_arg_ready", 32'(arg_ready), 32'd0);
    chk("t3_res_valid", 32'(res_valid), 32'd1);
    chk("t3_head_data", res_data, 32'h2);
    res_ready = 1'b1;
    drain("t3_drained");

    // 4: push into a full queue on the handshake edge is refused
    res_ready = 1'b0;
    push_five();
    arg_valid = 1'b1; arg_data = 32'h1234_5678; arg_mode = 2'd0; pend_exp = 32'hDEAD;
    res_ready = 1'b1;
    cyc();
    arg_valid = 1'b0;
    chk("t4_push_refused", 32'(last_push), 32'd0);
    chk("t4_occupancy", 32'(occupancy), 32'd3);
    chk("t4_arg_ready", 32'(arg_ready), 32'd1);
    chk("t4_valid_drop", 32'(res_valid), 32'd0);
    drain("t4_drained");

    // 5: reset in COMPUTE with two entries queued
    push_op(32'h0001_0001, 2'd0, 32'h2);
    push_op(32'h0000_00FF, 2'd2, 32'h8);
    push_op(32'h0101_0101, 2'd1, 32'h4);
    chk("t5_pre_occupancy", 32'(occupancy), 32'd2);
    chk("t5_pre_valid", 32'(res_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_arg_ready", 32'(arg_ready), 32'd0);
    cyc();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_occupancy", 32'(occupancy), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (res_valid) seen++;
    end
    chk("t5_no_result", 32'(seen), 32'd0);

    // 6: LATENCY=1, DEPTH=1 back-to-back
    b_arg_valid = 1'b1; b_arg_data = 32'h0001_0002; b_arg_mode = 2'd0;
    tick();
    b_arg_data = 32'h00FF_00FF; b_arg_mode = 2'd1;
    chk("t6_full", 32'(b_arg_ready), 32'd0);
    chk("t6_occ1", 32'(b_occupancy), 32'd1);
    tick();
    chk("t6_pop_valid", 32'(b_res_valid), 32'd0);
    chk("t6_pop_ready", 32'(b_arg_ready), 32'd1);
    tick();
    b_arg_data = 32'h8000_0001; b_arg_mode = 2'd2;
    chk("t6_r1_valid", 32'(b_res_valid), 32'd1);
    chk("t6_r1_data", b_res_data, 32'h3);
    chk("t6_r1_occ", 32'(b_occupancy), 32'd1);
    tick();
    chk("t6_gap1", 32'(b_res_valid), 32'd0);
    tick();
    b_arg_valid = 1'b0;
    chk("t6_r2_valid", 32'(b_res_valid), 32'd1);
    chk("t6_r2_data", b_res_data, 32'h1FE);
    tick();
    chk("t6_gap2", 32'(b_res_valid), 32'd0);
    tick();
    chk("t6_r3_valid", 32'(b_res_valid), 32'd1);
    chk("t6_r3_data", b_res_data, 32'h2);
    tick();
    chk("t6_done_valid", 32'(b_res_valid), 32'd0);
    chk("t6_done_busy", 32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
